// File: rtl/fetch_buffer.sv
`default_nettype none
// ============================================================================
// Module   : fetch_buffer
// Purpose  : Instruction fetch buffer behind the IF1 output register stage.
//            Packets are stored in a circular FIFO. Each packet holds a PC,
//            two instructions and exception info. The oldest packet is
//            presented to decode through a valid/ready handshake. The block
//            produces a full flag for fetch backpressure. A pipeline flush
//            discards every stored packet.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters:
//   DEPTH  number of packet entries (power of two, 2..32)
//   PTR_W  index width, derived from DEPTH
// Ports:
//   clk, rstn       clock; asynchronous active-low reset
//   flush           synchronous flush, empties the buffer
//   in_valid/ready  upstream handshake
//   in_pc, in_inst0, in_inst1, in_excp, in_badv   incoming packet
//   out_valid/ready downstream handshake to decode
//   out_pc, out_inst0, out_inst1, out_inst_vld, out_excp, out_badv
//                   head packet; forced to NOP / zero when empty
//   fetch_buf_full  buffer holds DEPTH entries
//   count           number of occupied entries
// Optional feature macro:
//   FETCH_BUF_BYPASS_EN  When defined, a packet arriving at an empty buffer
//                        is presented to decode in the same cycle. It is not
//                        written if decode takes it in that cycle.
// ============================================================================
module fetch_buffer #(
  parameter  int DEPTH = 8,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_pc,
  input  logic [31:0]      in_inst0,
  input  logic [31:0]      in_inst1,
  input  logic [6:0]       in_excp,
  input  logic [31:0]      in_badv,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_pc,
  output logic [31:0]      out_inst0,
  output logic [31:0]      out_inst1,
  output logic [1:0]       out_inst_vld,
  output logic [6:0]       out_excp,
  output logic [31:0]      out_badv,
  output logic             fetch_buf_full,
  output logic [PTR_W:0]   count
);

  localparam logic [31:0]  NOP_INST = 32'h0340_0000;
  localparam logic [PTR_W:0] PTR_ONE = {{PTR_W{1'b0}}, 1'b1};

  // Packet storage (no reset; contents are only read while valid)
  logic [31:0] mem_pc    [DEPTH];
  logic [31:0] mem_inst0 [DEPTH];
  logic [31:0] mem_inst1 [DEPTH];
  logic [6:0]  mem_excp  [DEPTH];
  logic [31:0] mem_badv  [DEPTH];

  // Pointers carry an extra wrap bit above the index
  logic [PTR_W:0]   wptr;
  logic [PTR_W:0]   rptr;
  logic [PTR_W-1:0] widx;
  logic [PTR_W-1:0] ridx;

  logic empty;
  logic full;
  logic push;
  logic pop;
  logic wr_en;
  logic bypass;
  logic show;

  assign widx  = wptr[PTR_W-1:0];
  assign ridx  = rptr[PTR_W-1:0];
  assign empty = (wptr == rptr);
  assign full  = (widx == ridx) && (wptr[PTR_W] != rptr[PTR_W]);
  assign count = wptr - rptr;
  assign fetch_buf_full = full;

  assign in_ready = !full && !flush;
  assign push     = in_valid && in_ready;

`ifdef FETCH_BUF_BYPASS_EN
  // The incoming packet drives the outputs directly while the buffer is empty
  assign bypass = empty && in_valid && !flush;
`else
  assign bypass = 1'b0;
`endif

  assign show      = !empty || bypass;
  assign out_valid = show && !flush;

  // A bypassed packet does not use the storage, so only a stored head moves rptr
  assign pop   = out_valid && out_ready && !empty;
  // A bypassed packet that decode accepts in the same cycle is never written
  assign wr_en = push && !(bypass && out_ready);

  // Pointer state
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wptr <= '0;
      rptr <= '0;
    end else if (flush) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (wr_en) wptr <= wptr + PTR_ONE;
      if (pop)   rptr <= rptr + PTR_ONE;
    end
  end

  // Storage write
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_pc[widx]    <= in_pc;
      mem_inst0[widx] <= in_inst0;
      mem_inst1[widx] <= in_inst1;
      mem_excp[widx]  <= in_excp;
      mem_badv[widx]  <= in_badv;
    end
  end

  // Head packet selection
  always_comb begin
    out_pc       = '0;
    out_inst0    = NOP_INST;
    out_inst1    = NOP_INST;
    out_excp     = '0;
    out_badv     = '0;
    out_inst_vld = 2'b00;
    if (!empty) begin
      out_pc    = mem_pc[ridx];
      out_inst0 = mem_inst0[ridx];
      out_inst1 = mem_inst1[ridx];
      out_excp  = mem_excp[ridx];
      out_badv  = mem_badv[ridx];
    end else if (bypass) begin
      out_pc    = in_pc;
      out_inst0 = in_inst0;
      out_inst1 = in_inst1;
      out_excp  = in_excp;
      out_badv  = in_badv;
    end
    // pc[2]=1 means slot0 lies before the fetch target. With an exception,
    // only the first valid slot is marked so that one slot carries the fault.
    if (show) begin
      if (out_pc[2])
        out_inst_vld = 2'b10;
      else if (out_excp != 7'd0)
        out_inst_vld = 2'b01;
      else
        out_inst_vld = 2'b11;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fetch_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_buffer
// Purpose  : Self-checking bench for fetch_buffer. It applies directed
//            table vectors and hand-written multi-cycle sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_buffer;

`ifdef FETCH_BUF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  localparam logic [31:0] NOP = 32'h0340_0000;

  logic        clk = 1'b0;
  logic        rstn;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_pc;
  logic [31:0] in_inst0;
  logic [31:0] in_inst1;
  logic [6:0]  in_excp;
  logic [31:0] in_badv;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_inst0;
  logic [31:0] out_inst1;
  logic [1:0]  out_inst_vld;
  logic [6:0]  out_excp;
  logic [31:0] out_badv;
  logic        fetch_buf_full;
  logic [3:0]  count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fetch_buffer #(.DEPTH(8)) dut (
    .clk(clk), .rstn(rstn), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_inst0(in_inst0), .in_inst1(in_inst1),
    .in_excp(in_excp), .in_badv(in_badv),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_inst0(out_inst0), .out_inst1(out_inst1),
    .out_inst_vld(out_inst_vld), .out_excp(out_excp), .out_badv(out_badv),
    .fetch_buf_full(fetch_buf_full), .count(count)
  );

  typedef struct {
    logic        fl;
    logic        iv;
    logic [31:0] pc;
    logic [6:0]  excp;
    logic [31:0] badv;
    logic        ordy;
    logic        e_ir;
    logic        e_ov;
    logic [31:0] e_pc;
    logic [1:0]  e_vld;
    logic [6:0]  e_excp;
    logic [31:0] e_badv;
    logic [3:0]  e_cnt;
  } vec_t;

  vec_t vecs[12];

  function automatic vec_t mk(input logic fl, input logic iv, input logic [31:0] pc,
                              input logic [6:0] excp, input logic [31:0] badv,
                              input logic ordy, input logic e_ir, input logic e_ov,
                              input logic [31:0] e_pc, input logic [1:0] e_vld,
                              input logic [6:0] e_excp, input logic [31:0] e_badv,
                              input logic [3:0] e_cnt);
    vec_t v;
    v.fl = fl; v.iv = iv; v.pc = pc; v.excp = excp; v.badv = badv; v.ordy = ordy;
    v.e_ir = e_ir; v.e_ov = e_ov; v.e_pc = e_pc; v.e_vld = e_vld;
    v.e_excp = e_excp; v.e_badv = e_badv; v.e_cnt = e_cnt;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs at the falling edge; outputs settle 1 time unit later
  task automatic drive(input logic fl, input logic iv, input logic [31:0] pc,
                       input logic [6:0] excp, input logic [31:0] badv, input logic ordy);
    @(negedge clk);
    flush     = fl;
    in_valid  = iv;
    in_pc     = pc;
    in_inst0  = pc ^ 32'h0280_0C21;
    in_inst1  = pc ^ 32'h0280_1042;
    in_excp   = excp;
    in_badv   = badv;
    out_ready = ordy;
    #1;
  endtask

  initial begin
    rstn = 1'b0; flush = 1'b0; in_valid = 1'b0; in_pc = '0; in_inst0 = '0;
    in_inst1 = '0; in_excp = '0; in_badv = '0; out_ready = 1'b0;

    // Stimulus table (default: no same-cycle bypass, so an empty head shows nothing)
    vecs[0]  = mk(0, 0, 32'h0,         7'h00, 32'h0,         0, 1, 0,   32'h0, 2'b00, 7'h00, 32'h0, 0);
    vecs[1]  = mk(0, 1, 32'h1C00_0000, 7'h00, 32'h0,         0, 1, BYP, BYP ? 32'h1C00_0000 : 32'h0,
                  BYP ? 2'b11 : 2'b00, 7'h00, 32'h0, 0);
    vecs[2]  = mk(0, 0, 32'h0,         7'h00, 32'h0,         0, 1, 1,   32'h1C00_0000, 2'b11, 7'h00, 32'h0, 1);
    vecs[3]  = mk(0, 0, 32'h0,         7'h00, 32'h0,         1, 1, 1,   32'h1C00_0000, 2'b11, 7'h00, 32'h0, 1);
    vecs[4]  = mk(0, 1, 32'h1C00_0014, 7'h08, 32'h1C00_0014, 0, 1, BYP, BYP ? 32'h1C00_0014 : 32'h0,
                  BYP ? 2'b10 : 2'b00, BYP ? 7'h08 : 7'h00, BYP ? 32'h1C00_0014 : 32'h0, 0);
    vecs[5]  = mk(0, 0, 32'h0,         7'h00, 32'h0,         1, 1, 1,   32'h1C00_0014, 2'b10, 7'h08, 32'h1C00_0014, 1);
    vecs[6]  = mk(0, 1, 32'h1C00_0000, 7'h08, 32'h1C00_0000, 0, 1, BYP, BYP ? 32'h1C00_0000 : 32'h0,
                  BYP ? 2'b01 : 2'b00, BYP ? 7'h08 : 7'h00, BYP ? 32'h1C00_0000 : 32'h0, 0);
    vecs[7]  = mk(0, 0, 32'h0,         7'h00, 32'h0,         1, 1, 1,   32'h1C00_0000, 2'b01, 7'h08, 32'h1C00_0000, 1);
    vecs[8]  = mk(0, 1, 32'h1C00_0004, 7'h00, 32'h0,         0, 1, BYP, BYP ? 32'h1C00_0004 : 32'h0,
                  BYP ? 2'b10 : 2'b00, 7'h00, 32'h0, 0);
    vecs[9]  = mk(0, 0, 32'h0,         7'h00, 32'h0,         1, 1, 1,   32'h1C00_0004, 2'b10, 7'h00, 32'h0, 1);
    vecs[10] = mk(0, 0, 32'h0,         7'h00, 32'h0,         1, 1, 0,   32'h0, 2'b00, 7'h00, 32'h0, 0);
    vecs[11] = mk(0, 0, 32'h0,         7'h00, 32'h0,         0, 1, 0,   32'h0, 2'b00, 7'h00, 32'h0, 0);

    // Reset held for three cycles
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_in_ready",  {31'd0, in_ready}, 32'd1);
    chk("rst_count",     {28'd0, count}, 32'd0);
    chk("rst_full",      {31'd0, fetch_buf_full}, 32'd0);
    chk("rst_inst0",     out_inst0, NOP);
    chk("rst_inst1",     out_inst1, NOP);
    @(negedge clk);
    rstn = 1'b1;

    // Table-driven vectors
    for (int i = 0; i < 12; i++) begin
      drive(vecs[i].fl, vecs[i].iv, vecs[i].pc, vecs[i].excp, vecs[i].badv, vecs[i].ordy);
      chk($sformatf("v%0d_in_ready", i),  {31'd0, in_ready},  {31'd0, vecs[i].e_ir});
      chk($sformatf("v%0d_out_valid", i), {31'd0, out_valid}, {31'd0, vecs[i].e_ov});
      chk($sformatf("v%0d_out_pc", i),    out_pc,             vecs[i].e_pc);
      chk($sformatf("v%0d_inst_vld", i),  {30'd0, out_inst_vld}, {30'd0, vecs[i].e_vld});
      chk($sformatf("v%0d_excp", i),      {25'd0, out_excp},  {25'd0, vecs[i].e_excp});
      chk($sformatf("v%0d_badv", i),      out_badv,           vecs[i].e_badv);
      chk($sformatf("v%0d_count", i),     {28'd0, count},     {28'd0, vecs[i].e_cnt});
    end

    // Fill to full, then try a ninth packet
    for (int k = 0; k < 8; k++) begin
      drive(0, 1, 32'h1C00_0000 + 32'(8 * k), 7'h00, 32'h0, 0);
      chk($sformatf("fill%0d_count", k), {28'd0, count}, 32'(k));
      chk($sformatf("fill%0d_in_ready", k), {31'd0, in_ready}, 32'd1);
    end
    drive(0, 1, 32'hDEAD_0000, 7'h00, 32'h0, 0);
    chk("full_flag",     {31'd0, fetch_buf_full}, 32'd1);
    chk("full_in_ready", {31'd0, in_ready}, 32'd0);
    chk("full_count",    {28'd0, count}, 32'd8);
    // Drain; the first pop coincides with in_valid while full and must not push
    for (int k = 0; k < 8; k++) begin
      drive(0, (k == 0), 32'hDEAD_0008, 7'h00, 32'h0, 1);
      chk($sformatf("drain%0d_pc", k),    out_pc, 32'h1C00_0000 + 32'(8 * k));
      chk($sformatf("drain%0d_valid", k), {31'd0, out_valid}, 32'd1);
      chk($sformatf("drain%0d_count", k), {28'd0, count}, 32'(8 - k));
    end
    drive(0, 0, 32'h0, 7'h00, 32'h0, 1);
    chk("drained_count", {28'd0, count}, 32'd0);
    chk("drained_valid", {31'd0, out_valid}, 32'd0);

    // Steady stream: three preloaded, then 20 cycles of simultaneous push/pop
    for (int k = 0; k < 3; k++) drive(0, 1, 32'h2000_0000 + 32'(8 * k), 7'h00, 32'h0, 0);
    for (int j = 0; j < 20; j++) begin
      drive(0, 1, 32'h2000_0000 + 32'(8 * (j + 3)), 7'h00, 32'h0, 1);
      chk($sformatf("stream%0d_pc", j),    out_pc, 32'h2000_0000 + 32'(8 * j));
      chk($sformatf("stream%0d_count", j), {28'd0, count}, 32'd3);
    end
    for (int j = 20; j < 23; j++) begin
      drive(0, 0, 32'h0, 7'h00, 32'h0, 1);
      chk($sformatf("stream_drain%0d_pc", j), out_pc, 32'h2000_0000 + 32'(8 * j));
    end
    drive(0, 0, 32'h0, 7'h00, 32'h0, 0);
    chk("stream_end_count", {28'd0, count}, 32'd0);

    // Flush with five entries held and a packet offered in the same cycle
    for (int k = 0; k < 5; k++) drive(0, 1, 32'h3000_0000 + 32'(8 * k), 7'h00, 32'h0, 0);
    drive(1, 1, 32'h3000_0100, 7'h00, 32'h0, 1);
    chk("flush_out_valid", {31'd0, out_valid}, 32'd0);
    chk("flush_in_ready",  {31'd0, in_ready}, 32'd0);
    chk("flush_count_pre", {28'd0, count}, 32'd5);
    drive(0, 0, 32'h0, 7'h00, 32'h0, 0);
    chk("flush_count_post", {28'd0, count}, 32'd0);
    chk("flush_valid_post", {31'd0, out_valid}, 32'd0);
    chk("flush_pc_post",    out_pc, 32'd0);

    // Flush held for several cycles with in_valid high
    for (int k = 0; k < 3; k++) begin
      drive(1, 1, 32'h4000_0000, 7'h00, 32'h0, 1);
      chk($sformatf("mflush%0d_in_ready", k),  {31'd0, in_ready}, 32'd0);
      chk($sformatf("mflush%0d_out_valid", k), {31'd0, out_valid}, 32'd0);
      chk($sformatf("mflush%0d_count", k),     {28'd0, count}, 32'd0);
    end
    drive(0, 0, 32'h0, 7'h00, 32'h0, 0);
    chk("mflush_after_count", {28'd0, count}, 32'd0);

`ifdef FETCH_BUF_BYPASS_EN
    // Same-cycle bypass into an empty buffer
    drive(0, 1, 32'h5000_0008, 7'h00, 32'h0, 1);
    chk("byp_out_valid", {31'd0, out_valid}, 32'd1);
    chk("byp_out_pc",    out_pc, 32'h5000_0008);
    chk("byp_inst0",     out_inst0, 32'h5000_0008 ^ 32'h0280_0C21);
    chk("byp_count",     {28'd0, count}, 32'd0);
    drive(0, 0, 32'h0, 7'h00, 32'h0, 0);
    chk("byp_after_count", {28'd0, count}, 32'd0);
    chk("byp_after_valid", {31'd0, out_valid}, 32'd0);
`endif

    // Asynchronous reset in mid-operation
    drive(0, 1, 32'h6000_0000, 7'h00, 32'h0, 0);
    drive(0, 1, 32'h6000_0008, 7'h00, 32'h0, 0);
    drive(0, 0, 32'h0, 7'h00, 32'h0, 0);
    chk("pre_arst_count", {28'd0, count}, 32'd2);
    rstn = 1'b0;
    #1;
    chk("arst_count",     {28'd0, count}, 32'd0);
    chk("arst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("arst_in_ready",  {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    rstn = 1'b1;
    drive(0, 0, 32'h0, 7'h00, 32'h0, 0);
    chk("post_arst_count", {28'd0, count}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
